// File: rtl/temp_monitor.sv
// Temperature monitor for a 1-wire sensor reader.
//
// Takes one raw sample on each rising edge of done, checks it, and keeps a 4-sample
// moving average. An over-temperature alarm with hysteresis follows that average. A
// watchdog restarts the sensor if no result arrives for WDOG_CYCLES clocks.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   done       result-ready flag from the reader (rising edge significant)
//   temp_data  raw two's-complement sample, LSB = 1/16 degC
//   t_hi       signed alarm threshold
//   t_hyst     unsigned alarm hysteresis
//   sens_rst   reset request to the reader, high for RST_LEN cycles
//   temp_avg   signed 4-sample moving average
//   avg_valid  one-cycle strobe, temp_avg updated
//   alarm      over-temperature flag
//   fault      last event was an invalid sample or a watchdog restart
//   err_cnt    saturating error counter
module temp_monitor #(
  parameter int unsigned WDOG_CYCLES = 125000000,
  parameter int unsigned RST_LEN     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        done,
  input  logic [15:0] temp_data,
  input  logic [15:0] t_hi,
  input  logic [7:0]  t_hyst,
  output logic        sens_rst,
  output logic [15:0] temp_avg,
  output logic        avg_valid,
  output logic        alarm,
  output logic        fault,
  output logic [7:0]  err_cnt
);

  localparam int unsigned WdogW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam int unsigned RstW  = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);
  localparam logic [RstW-1:0]  RstLast  = RstW'(RST_LEN - 1);
  localparam logic [15:0] PowerOnVal = 16'h0550;

  typedef enum logic [1:0] {StWait, StCheck, StAccum, StRestart} state_e;

  state_e            state_q, state_d;
  logic              done_q;
  logic [15:0]       sample_q, sample_d;
  logic [15:0]       smp_q [4];
  logic [15:0]       smp_d [4];
  logic [15:0]       smp_new [4];
  logic [2:0]        fill_q, fill_d, fill_inc;
  logic              discard_q, discard_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;
  logic [RstW-1:0]   rcnt_q, rcnt_d;
  logic [15:0]       avg_q, avg_d, avg_new;
  logic              avg_valid_q, avg_valid_d;
  logic              alarm_q, alarm_d;
  logic              fault_q, fault_d;
  logic [7:0]        err_q, err_d, err_inc;

  logic              edge_det;
  logic              sample_ok;
  logic signed [17:0] sum, avg18, hi18, lo18;

  function automatic logic signed [17:0] sext18(input logic [15:0] v);
    return $signed({{2{v[15]}}, v});
  endfunction

  assign edge_det  = done & ~done_q;
  assign sample_ok = ($signed(sample_q) >= -16'sd880) && ($signed(sample_q) <= 16'sd2000);
  assign err_inc   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  assign fill_inc  = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;

  // Buffer contents after shifting in the current sample; newest at index 0.
  always_comb begin
    smp_new[0] = sample_q;
    for (int i = 1; i < 4; i++) begin
      smp_new[i] = smp_q[i-1];
    end
  end

  // Arithmetic shift right by 2 of the 18-bit sum is simply bits [17:2] (floor).
  assign sum     = sext18(smp_new[0]) + sext18(smp_new[1]) + sext18(smp_new[2]) +
                   sext18(smp_new[3]);
  assign avg_new = sum[17:2];
  assign avg18   = sext18(avg_new);
  assign hi18    = sext18(t_hi);
  assign lo18    = hi18 - $signed({10'd0, t_hyst});

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    smp_d       = smp_q;
    fill_d      = fill_q;
    discard_d   = discard_q;
    wdog_d      = '0;
    rcnt_d      = '0;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    alarm_d     = alarm_q;
    fault_d     = fault_q;
    err_d       = err_q;

    unique case (state_q)
      StWait: begin
        // An edge wins over a coinciding watchdog expiry.
        if (edge_det) begin
          sample_d = temp_data;
          state_d  = StCheck;
        end else if (wdog_q == WdogLast) begin
          state_d   = StRestart;
          fault_d   = 1'b1;
          err_d     = err_inc;
          fill_d    = 3'd0;
          discard_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
        end
      end
      StCheck: begin
        state_d   = StWait;
        discard_d = 1'b0;
        if (discard_q && (sample_q == PowerOnVal)) begin
          // Power-on default reading straight after a (re)start: drop it quietly.
        end else if (sample_ok) begin
          state_d = StAccum;
          fault_d = 1'b0;
          smp_d   = smp_new;
          fill_d  = fill_inc;
          if (fill_inc == 3'd4) begin
            avg_valid_d = 1'b1;
            avg_d       = avg_new;
            if (avg18 > hi18) begin
              alarm_d = 1'b1;
            end else if (avg18 < lo18) begin
              alarm_d = 1'b0;
            end
          end
        end else begin
          fault_d = 1'b1;
          err_d   = err_inc;
        end
      end
      StAccum: begin
        state_d = StWait;
      end
      StRestart: begin
        if (rcnt_q == RstLast) begin
          state_d = StWait;
        end else begin
          rcnt_d = rcnt_q + RstW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWait;
      done_q      <= 1'b0;
      sample_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        smp_q[i] <= '0;
      end
      fill_q      <= '0;
      discard_q   <= 1'b1;
      wdog_q      <= '0;
      rcnt_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
      fault_q     <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done;
      sample_q    <= sample_d;
      smp_q       <= smp_d;
      fill_q      <= fill_d;
      discard_q   <= discard_d;
      wdog_q      <= wdog_d;
      rcnt_q      <= rcnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      alarm_q     <= alarm_d;
      fault_q     <= fault_d;
      err_q       <= err_d;
    end
  end

  // Decoded from state so that reset drops the request immediately.
  assign sens_rst  = (state_q == StRestart);
  assign temp_avg  = avg_q;
  assign avg_valid = avg_valid_q;
  assign alarm     = alarm_q;
  assign fault     = fault_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_temp_monitor.sv
// Self-checking bench for temp_monitor with a behavioural model of the sample path.
module tb_temp_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        done = 1'b0;
  logic [15:0] temp_data = '0;
  logic [15:0] t_hi = 16'd2000;
  logic [7:0]  t_hyst = 8'd0;
  logic        sens_rst;
  logic [15:0] temp_avg;
  logic        avg_valid;
  logic        alarm;
  logic        fault;
  logic [7:0]  err_cnt;

  temp_monitor #(
    .WDOG_CYCLES(1000),
    .RST_LEN    (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .done     (done),
    .temp_data(temp_data),
    .t_hi     (t_hi),
    .t_hyst   (t_hyst),
    .sens_rst (sens_rst),
    .temp_avg (temp_avg),
    .avg_valid(avg_valid),
    .alarm    (alarm),
    .fault    (fault),
    .err_cnt  (err_cnt)
  );

  always #4 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  int mq[$];
  bit m_disc;
  bit m_fault;
  bit m_alarm;
  int m_err;
  int m_th = 2000;
  int m_hy = 0;

  task automatic model_reset();
    mq.delete();
    m_disc  = 1;
    m_fault = 0;
    m_alarm = 0;
    m_err   = 0;
  endtask

  task automatic model_restart();
    mq.delete();
    m_disc  = 1;
    m_fault = 1;
    if (m_err < 255) m_err++;
  endtask

  function automatic int floor_div4(input int s);
    if (s >= 0) return s / 4;
    return -((-s + 3) / 4);
  endfunction

  task automatic set_thresholds(input int th, input int hy);
    m_th   = th;
    m_hy   = hy;
    t_hi   = 16'(th);
    t_hyst = 8'(hy);
  endtask

  // Sends one sample and checks the outcome at E+1, E+2 and E+3.
  task automatic send(input int v);
    bit ev = 0;
    int ea = 0;
    int s;
    if (m_disc && v == 1360) begin
      m_disc = 0;
    end else begin
      m_disc = 0;
      if (v >= -880 && v <= 2000) begin
        m_fault = 0;
        mq.push_front(v);
        if (mq.size() > 4) void'(mq.pop_back());
        if (mq.size() == 4) begin
          s = 0;
          foreach (mq[i]) s += mq[i];
          ea = floor_div4(s);
          ev = 1;
          if (ea > m_th) m_alarm = 1;
          else if (ea < m_th - m_hy) m_alarm = 0;
        end
      end else begin
        m_fault = 1;
        if (m_err < 255) m_err++;
      end
    end
    @(posedge clk); #1;
    temp_data = 16'(v);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    checks++;
    if (avg_valid !== 1'b0) begin
      failures++;
      $display("FAIL early_valid v=%0d: got %b expected 0", v, avg_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (avg_valid !== ev) begin
      failures++;
      $display("FAIL avg_valid v=%0d: got %b expected %b", v, avg_valid, ev);
    end
    if (ev) begin
      checks++;
      if (int'($signed(temp_avg)) !== ea) begin
        failures++;
        $display("FAIL temp_avg v=%0d: got %0d expected %0d", v, $signed(temp_avg), ea);
      end
      checks++;
      if (alarm !== m_alarm) begin
        failures++;
        $display("FAIL alarm_at_valid v=%0d: got %b expected %b", v, alarm, m_alarm);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (avg_valid !== 1'b0 || fault !== m_fault || int'(err_cnt) !== m_err ||
        alarm !== m_alarm) begin
      failures++;
      $display("FAIL status v=%0d: got valid=%b fault=%b err=%0d alarm=%b expected 0 %b %0d %b",
               v, avg_valid, fault, err_cnt, alarm, m_fault, m_err, m_alarm);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (sens_rst !== 1'b0 || temp_avg !== 16'd0 || avg_valid !== 1'b0 || alarm !== 1'b0 ||
        fault !== 1'b0 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL %s: got rst=%b avg=%0d valid=%b alarm=%b fault=%b err=%0d expected all 0",
               name, sens_rst, temp_avg, avg_valid, alarm, fault, err_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("after_release");
  endtask

  task automatic test_discard_avg();
    send(1360);
    send(400);
    send(400);
    send(404);
    send(404);
    checks++;
    if (temp_avg !== 16'd402) begin
      failures++;
      $display("FAIL avg_402: got %0d expected 402", temp_avg);
    end
  endtask

  task automatic test_negative();
    send(-1);
    send(-1);
    send(-1);
    send(-2);
    checks++;
    if (temp_avg !== 16'hFFFE) begin
      failures++;
      $display("FAIL avg_neg: got %h expected fffe", temp_avg);
    end
  endtask

  task automatic test_alarm();
    set_thresholds(800, 32);
    repeat (4) send(801);
    checks++;
    if (alarm !== 1'b1) begin
      failures++;
      $display("FAIL alarm_set: got %b expected 1", alarm);
    end
    repeat (4) send(790);
    checks++;
    if (alarm !== 1'b1) begin
      failures++;
      $display("FAIL alarm_hold: got %b expected 1", alarm);
    end
    repeat (4) send(767);
    checks++;
    if (alarm !== 1'b0) begin
      failures++;
      $display("FAIL alarm_clear: got %b expected 0", alarm);
    end
  endtask

  task automatic test_invalid();
    send(2001);
    checks++;
    if (fault !== 1'b1 || err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL invalid_fault: got fault=%b err=%0d expected 1 1", fault, err_cnt);
    end
    send(-881);
    send(400);
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_clear: got %b expected 0", fault);
    end
  endtask

  task automatic test_random();
    int v;
    int r;
    set_thresholds(int'($urandom_range(1700)) - 200, int'($urandom_range(255)));
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(9));
      if (r == 0) v = 2001 + int'($urandom_range(3000));
      else if (r == 1) v = -881 - int'($urandom_range(3000));
      else if (r == 2) v = 1360;
      else v = int'($urandom_range(2880)) - 880;
      send(v);
    end
  endtask

  task automatic test_watchdog();
    int n = 0;
    int hi = 0;
    set_thresholds(2000, 0);
    send(500);
    while (sens_rst !== 1'b1 && n < 1100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 1000) begin
      failures++;
      $display("FAIL wdog_delay: got %0d cycles expected 1000", n);
    end
    if (sens_rst !== 1'b1) return;
    model_restart();
    checks++;
    if (fault !== 1'b1 || int'(err_cnt) !== m_err) begin
      failures++;
      $display("FAIL wdog_fault: got fault=%b err=%0d expected 1 %0d", fault, err_cnt, m_err);
    end
    temp_data = 16'd300;
    while (sens_rst === 1'b1 && hi < 40) begin
      hi++;
      done = (hi == 5);
      @(posedge clk); #1;
    end
    done = 1'b0;
    checks++;
    if (hi !== 16) begin
      failures++;
      $display("FAIL sens_rst_len: got %0d expected 16", hi);
    end
    send(500);
    send(504);
    send(508);
    send(512);
  endtask

  task automatic test_reset_mid_restart();
    int n = 0;
    while (sens_rst !== 1'b1 && n < 1100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sens_rst !== 1'b1) begin
      failures++;
      $display("FAIL wdog_timeout: got sens_rst=%b expected 1", sens_rst);
      return;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_restart");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send(1360);
    send(600);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_discard_avg();
    test_negative();
    test_alarm();
    test_invalid();
    test_random();
    test_watchdog();
    test_reset_mid_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
